// File: rtl/elbeth_if_stage.sv
// Instruction fetch: owns the PC and drives imem over req/ready. Outputs are registered, so data lands one cycle after ready.
// On stall a ready word parks in a one-entry skid buffer. Misaligned-target trap is enabled by `ELBETH_IF_MISALIGN_EN.
module elbeth_if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ctrl_stall,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc,
`ifdef ELBETH_IF_MISALIGN_EN
  output logic        if_exc_misaligned,
`endif
  output logic        if_valid
);

`ifdef ELBETH_IF_MISALIGN_EN
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_TRAP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic        vld_q, vld_d;
  logic [31:0] skid_dat_q, skid_dat_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        skid_vld_q, skid_vld_d;
`ifdef ELBETH_IF_MISALIGN_EN
  logic        exc_q, exc_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      ifpc_q     <= 32'h0000_0000;
      vld_q      <= 1'b0;
      skid_dat_q <= 32'h0000_0000;
      skid_pc_q  <= 32'h0000_0000;
      skid_vld_q <= 1'b0;
`ifdef ELBETH_IF_MISALIGN_EN
      exc_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      ifpc_q     <= ifpc_d;
      vld_q      <= vld_d;
      skid_dat_q <= skid_dat_d;
      skid_pc_q  <= skid_pc_d;
      skid_vld_q <= skid_vld_d;
`ifdef ELBETH_IF_MISALIGN_EN
      exc_q      <= exc_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    ifpc_d     = ifpc_q;
    vld_d      = vld_q;
    skid_dat_d = skid_dat_q;
    skid_pc_d  = skid_pc_q;
    skid_vld_d = skid_vld_q;
`ifdef ELBETH_IF_MISALIGN_EN
    exc_d      = exc_q;
`endif
    // Redirect beats stall and ready; any word returned this cycle is dropped.
    if (ex_branch_taken) begin
      skid_vld_d = 1'b0;
      instr_d    = NOP_INSTR;
`ifdef ELBETH_IF_MISALIGN_EN
      pc_d = ex_branch_target;
      if (ex_branch_target[1:0] != 2'b00) begin
        state_d = S_TRAP;
        vld_d   = 1'b1;
        ifpc_d  = ex_branch_target;
        exc_d   = 1'b1;
      end else begin
        state_d = S_FETCH;
        vld_d   = 1'b0;
        exc_d   = 1'b0;
      end
`else
      pc_d    = ex_branch_target & ~32'h0000_0003;
      state_d = S_FETCH;
      vld_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: state_d = S_FETCH;
        S_FETCH: begin
          if (imem_ready) begin
            pc_d = pc_q + 32'd4;
            if (ctrl_stall) begin
              skid_dat_d = imem_data;
              skid_pc_d  = pc_q;
              skid_vld_d = 1'b1;
              state_d    = S_HOLD;
            end else begin
              instr_d = imem_data;
              ifpc_d  = pc_q;
              vld_d   = 1'b1;
            end
          end else if (!ctrl_stall) begin
            instr_d = NOP_INSTR;
            vld_d   = 1'b0;
          end
        end
        S_HOLD: begin
          if (!ctrl_stall) begin
            instr_d    = skid_dat_q;
            ifpc_d     = skid_pc_q;
            vld_d      = skid_vld_q;
            skid_vld_d = 1'b0;
            state_d    = S_FETCH;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  assign imem_req       = (state_q == S_FETCH);
  assign imem_addr      = pc_q;
  assign if_instruction = instr_q;
  assign if_pc          = ifpc_q;
  assign if_valid       = vld_q;
`ifdef ELBETH_IF_MISALIGN_EN
  assign if_exc_misaligned = exc_q;
`endif

endmodule

// File: tb/tb_elbeth_if_stage.sv
// Directed bench for elbeth_if_stage: linear steps, immediate-assertion checks.
module tb_elbeth_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        ctrl_stall;
  logic        ex_branch_taken;
  logic [31:0] ex_branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_data;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic        if_valid;
`ifdef ELBETH_IF_MISALIGN_EN
  logic        if_exc_misaligned;
`endif

  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic        w_valid;
`ifdef ELBETH_IF_MISALIGN_EN
  logic        w_exc;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign imem_data = word(imem_addr);
  assign w_data    = word(w_addr);

  elbeth_if_stage u_dut (
    .clk              (clk),
    .rst              (rst),
    .ctrl_stall       (ctrl_stall),
    .ex_branch_taken  (ex_branch_taken),
    .ex_branch_target (ex_branch_target),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ready       (imem_ready),
    .imem_data        (imem_data),
    .if_instruction   (if_instruction),
    .if_pc            (if_pc),
`ifdef ELBETH_IF_MISALIGN_EN
    .if_exc_misaligned(if_exc_misaligned),
`endif
    .if_valid         (if_valid)
  );

  elbeth_if_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk              (clk),
    .rst              (rst),
    .ctrl_stall       (1'b0),
    .ex_branch_taken  (1'b0),
    .ex_branch_target (32'h0000_0000),
    .imem_req         (w_req),
    .imem_addr        (w_addr),
    .imem_ready       (1'b1),
    .imem_data        (w_data),
    .if_instruction   (w_instr),
    .if_pc            (w_pc),
`ifdef ELBETH_IF_MISALIGN_EN
    .if_exc_misaligned(w_exc),
`endif
    .if_valid         (w_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; ctrl_stall = 1'b0; ex_branch_taken = 1'b0;
    ex_branch_target = 32'h0; imem_ready = 1'b1;
    tick(); tick();
    check("rst_valid", {31'b0, if_valid}, 32'd0);
    check("rst_instr", if_instruction, NOP);
    check("rst_pc", if_pc, 32'h0);
    rst = 1'b0;
    check("idle_req", {31'b0, imem_req}, 32'd0);

    // Startup sequence, ready always high
    tick();
    check("f0_req", {31'b0, imem_req}, 32'd1);
    check("f0_addr", imem_addr, 32'h0);
    check("f0_valid", {31'b0, if_valid}, 32'd0);
    check("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    tick();
    check("o0_pc", if_pc, 32'h0);
    check("o0_instr", if_instruction, 32'hC0DE_0000);
    check("o0_valid", {31'b0, if_valid}, 32'd1);
    check("o0_addr", imem_addr, 32'h4);
    check("wrap_pc0", w_pc, 32'hFFFF_FFFC);
    check("wrap_instr0", w_instr, 32'h3F21_FFFC);
    tick();
    check("o1_pc", if_pc, 32'h4);
    check("o1_addr", imem_addr, 32'h8);
    check("wrap_pc1", w_pc, 32'h0000_0000);
    check("wrap_valid1", {31'b0, w_valid}, 32'd1);

    // Three cycles of ready low at pc=8
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bub_valid", {31'b0, if_valid}, 32'd0);
      check("bub_instr", if_instruction, NOP);
      check("bub_pc", if_pc, 32'h4);
      check("bub_addr", imem_addr, 32'h8);
      check("bub_req", {31'b0, imem_req}, 32'd1);
    end
    imem_ready = 1'b1;
    tick();
    check("o8_pc", if_pc, 32'h8);
    check("o8_instr", if_instruction, 32'hC0DE_0008);
    check("o8_valid", {31'b0, if_valid}, 32'd1);
    tick();
    check("oC_pc", if_pc, 32'hC);
    check("oC_addr", imem_addr, 32'h10);

    // Stall four cycles coinciding with ready at pc=0x10
    ctrl_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_req", {31'b0, imem_req}, 32'd0);
      check("hold_pc", if_pc, 32'hC);
      check("hold_instr", if_instruction, 32'hC0DE_000C);
      check("hold_valid", {31'b0, if_valid}, 32'd1);
    end
    ctrl_stall = 1'b0;
    tick();
    check("skid_pc", if_pc, 32'h10);
    check("skid_instr", if_instruction, 32'hC0DE_0010);
    check("skid_valid", {31'b0, if_valid}, 32'd1);
    check("skid_addr", imem_addr, 32'h14);
    tick();
    check("o14_pc", if_pc, 32'h14);
    check("o14_instr", if_instruction, 32'hC0DE_0014);

    // Redirect together with stall and ready
    ex_branch_taken = 1'b1; ex_branch_target = 32'h200; ctrl_stall = 1'b1;
    tick();
    ex_branch_taken = 1'b0; ctrl_stall = 1'b0;
    check("br_valid", {31'b0, if_valid}, 32'd0);
    check("br_instr", if_instruction, NOP);
    check("br_addr", imem_addr, 32'h200);
    check("br_req", {31'b0, imem_req}, 32'd1);
    tick();
    check("br_pc", if_pc, 32'h200);
    check("br_dat", if_instruction, 32'hC0DE_0200);
    check("br_v1", {31'b0, if_valid}, 32'd1);

    // Misaligned redirect
    ex_branch_taken = 1'b1; ex_branch_target = 32'h102;
    tick();
    ex_branch_taken = 1'b0;
`ifdef ELBETH_IF_MISALIGN_EN
    check("trap_exc", {31'b0, if_exc_misaligned}, 32'd1);
    check("trap_pc", if_pc, 32'h102);
    check("trap_valid", {31'b0, if_valid}, 32'd1);
    check("trap_instr", if_instruction, NOP);
    check("trap_req", {31'b0, imem_req}, 32'd0);
    tick();
    check("trap_req2", {31'b0, imem_req}, 32'd0);
    check("trap_pc2", if_pc, 32'h102);
    ex_branch_taken = 1'b1; ex_branch_target = 32'h100;
    tick();
    ex_branch_taken = 1'b0;
    check("untrap_exc", {31'b0, if_exc_misaligned}, 32'd0);
`endif
    check("mis_req", {31'b0, imem_req}, 32'd1);
    check("mis_addr", imem_addr, 32'h100);
    check("mis_valid", {31'b0, if_valid}, 32'd0);
    tick();
    check("mis_pc", if_pc, 32'h100);
    check("mis_instr", if_instruction, 32'hC0DE_0100);

    // Reset while parked in the hold state
    ctrl_stall = 1'b1;
    tick();
    check("pre_rst_req", {31'b0, imem_req}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0; ctrl_stall = 1'b0;
    check("mrst_valid", {31'b0, if_valid}, 32'd0);
    check("mrst_instr", if_instruction, NOP);
    check("mrst_pc", if_pc, 32'h0);
    check("mrst_req", {31'b0, imem_req}, 32'd0);
    check("mrst_addr", imem_addr, 32'h0);
    tick();
    check("mrst_f_addr", imem_addr, 32'h0);
    tick();
    check("mrst_o_pc", if_pc, 32'h0);
    check("mrst_o_instr", if_instruction, 32'hC0DE_0000);
    tick();
    check("mrst_o2_pc", if_pc, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
